// File: rtl/sad_pkg.sv
// Shared definitions for the sum-of-absolute-differences block controller:
// FSM state encoding and the default block size / result width.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default number of operand pairs per block.
    localparam int N_DEF     = 8;
    // Default accumulator/result width; 15*N_DEF must fit.
    localparam int SUM_W_DEF = 8;

endpackage

// File: rtl/abs_dif.sv
// Unsigned 4-bit absolute difference |aIn - bIn|.
module abs_dif (
    input  logic [3:0] aIn,
    input  logic [3:0] bIn,
    output logic [3:0] out
);

    // Subtract the smaller operand from the larger so the result is never negative.
    always_comb begin
        if (aIn >= bIn) begin
            out = aIn - bIn;
        end else begin
            out = bIn - aIn;
        end
    end

endmodule

// File: rtl/sad_ctrl.sv
// Block controller that accumulates |a-b| over N accepted operand pairs and
// publishes the total on sum_out with a one-cycle done pulse.
module sad_ctrl
    import sad_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a_in,
    input  logic [3:0]       b_in,
    output logic [SUM_W-1:0] sum_out,
    output logic             done,
    output logic             busy
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t             state_r;
    state_t             state_nxt;
    logic [SUM_W-1:0]   acc_r;
    logic [SUM_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SUM_W-1:0]   sum_r;
    logic [SUM_W-1:0]   sum_nxt;
    logic               in_ready_r;
    logic               busy_r;
    logic               done_r;
    logic [3:0]         abs_s;
    logic [SUM_W-1:0]   abs_ext_s;
    logic [SUM_W-1:0]   acc_add_s;
    logic               accept_s;

    // The single absolute-difference unit shared by every accept.
    abs_dif u_abs_dif (
        .aIn (a_in),
        .bIn (b_in),
        .out (abs_s)
    );

    assign abs_ext_s = {{(SUM_W-4){1'b0}}, abs_s};
    assign acc_add_s = acc_r + abs_ext_s;
    // in_ready_r mirrors state_r == RUN, so this is the handshake as seen outside.
    assign accept_s  = in_valid && in_ready_r;

    // Next-state, accumulator, counter and result update rules.
    always_comb begin
        state_nxt = state_r;
        acc_nxt   = acc_r;
        cnt_nxt   = cnt_r;
        sum_nxt   = sum_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    acc_nxt = acc_add_s;
                    if (cnt_r == LAST_CNT) begin
                        // Final pair: publish the total; the counter is left
                        // at N-1 and only restarts through the clear on start.
                        state_nxt = DONE;
                        sum_nxt   = acc_add_s;
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            acc_r      <= '0;
            cnt_r      <= '0;
            sum_r      <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            acc_r      <= acc_nxt;
            cnt_r      <= cnt_nxt;
            sum_r      <= sum_nxt;
            in_ready_r <= (state_nxt == RUN);
            busy_r     <= (state_nxt == RUN) || (state_nxt == DONE);
            done_r     <= (state_nxt == DONE);
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sum_out  = sum_r;

endmodule

// File: tb/tb_sad_ctrl.sv
// Scoreboard bench for sad_ctrl: stimulus pushes the expected block sum,
// an independent monitor pops and compares on every done pulse.
module tb_sad_ctrl;

    localparam int N     = 8;
    localparam int SUM_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a_in;
    logic [3:0]       b_in;
    logic [SUM_W-1:0] sum_out;
    logic             done;
    logic             busy;

    int checks;
    int failures;
    int done_seen;
    int blocks_sent;
    int exp_q[$];
    int pa[N];
    int pb[N];

    sad_ctrl #(.N(N), .SUM_W(SUM_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .sum_out  (sum_out),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must carry the oldest outstanding block sum.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got sum %0d with no block outstanding", sum_out);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(sum_out) != e) begin
                    failures++;
                    $display("FAIL sum_out: got %0d expected %0d", sum_out, e);
                end
            end
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL done_flags: got in_ready=%0b busy=%0b expected 0/1", in_ready, busy);
            end
        end
    end

    // Run one block from IDLE using pa/pb; gap idle cycles after each pair,
    // optional start pulse after pair number pulse_after, optional start in DONE.
    task automatic run_block(input int gap, input int pulse_after, input bit start_in_done);
        int exp;
        int n;
        exp = 0;
        for (int i = 0; i < N; i++) exp += absd(pa[i], pb[i]);
        exp_q.push_back(exp);
        blocks_sent++;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_entry_ready", int'(in_ready), 1);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            a_in = 4'(pa[i]);
            b_in = 4'(pb[i]);
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            if (!in_ready) begin
                chk("ready_timeout", 0, 1);
            end else begin
                tick();
            end
            in_valid = 1'b0;
            a_in = 4'($urandom_range(15));
            b_in = 4'($urandom_range(15));
            if (i == N - 1) begin
                chk("done_latency", int'(done), 1);
            end else begin
                chk("no_early_done", int'(done), 0);
                if (i + 1 == pulse_after) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    chk("start_ignored_run", int'(in_ready), 1);
                end
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_busy", int'(busy), 1);
                end
            end
        end
        start = start_in_done;
        tick();
        start = 1'b0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(in_ready), 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        done_seen = 0;
        blocks_sent = 0;
        start = 1'b0;
        in_valid = 1'b0;
        a_in = 4'd0;
        b_in = 4'd0;
        rst_n = 1'b0;
        #23;
        chk("rst_sum", int'(sum_out), 0);
        chk("rst_flags", int'({done, busy, in_ready}), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_no_start", int'(busy), 0);

        // Uniform block: 8 x (3,12) -> 72
        for (int i = 0; i < N; i++) begin pa[i] = 3; pb[i] = 12; end
        run_block(0, 0, 1'b0);

        // Hold: sum_out keeps 72 through idle and a new start
        for (int i = 0; i < 10; i++) tick();
        chk("hold_idle", int'(sum_out), 72);
        for (int i = 0; i < N; i++) begin pa[i] = (i % 4 == 0) ? 3 : (i % 4 == 1) ? 10 : (i % 4 == 2) ? 5 : 12;
                                          pb[i] = (i % 4 == 0) ? 12 : (i % 4 == 1) ? 4 : (i % 4 == 2) ? 5 : 0; end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_after_start", int'(sum_out), 72);
        // Abort this extra start via reset later is not wanted; finish it as the mixed block (54).
        exp_q.push_back(54);
        blocks_sent++;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            a_in = 4'(pa[i]);
            b_in = 4'(pb[i]);
            tick();
            if (i < N - 1) chk("hold_in_run", int'(sum_out), 72);
        end
        in_valid = 1'b0;
        chk("mixed_done_latency", int'(done), 1);
        tick();
        chk("mixed_idle", int'(busy), 0);

        // Max with gaps: 8 x (15,0), 2 idle cycles between pairs, start in DONE ignored
        for (int i = 0; i < N; i++) begin pa[i] = 15; pb[i] = 0; end
        run_block(2, 0, 1'b1);
        tick();
        chk("done_start_ignored", int'(in_ready), 0);

        // Ignored start after the 3rd accept: 8 x (0,9) -> 72
        for (int i = 0; i < N; i++) begin pa[i] = 0; pb[i] = 9; end
        run_block(0, 3, 1'b0);

        // Reset mid-block after 3 pairs of (15,0)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a_in = 4'd15; b_in = 4'd0;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", int'(sum_out), 0);
        chk("midrst_flags", int'({done, busy, in_ready}), 0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        chk("post_rst_waits_start", int'(in_ready), 0);
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin pa[i] = 10; pb[i] = 4; end
        run_block(0, 0, 1'b0);
        chk("post_rst_sum", int'(sum_out), 48);

        // Randomized blocks with random gaps and stray start pulses
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                pa[i] = int'($urandom_range(15));
                pb[i] = int'($urandom_range(15));
            end
            run_block(int'($urandom_range(2)), int'($urandom_range(N - 1)), 1'($urandom_range(1)));
            for (int k = 0; k < int'($urandom_range(3)); k++) tick();
        end

        tick();
        tick();
        chk("done_count", done_seen, blocks_sent);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_ctrl.md
SAD_CTRL -- requirements
Module: sad_ctrl

Interface
REQ-001 Parameter N, 8, number of operand pairs per block; N >= 2.
REQ-002 Parameter SUM_W, 8, accumulator and result width; 15*N <= 2^SUM_W - 1 SHALL hold.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a new block; sampled only in IDLE.
REQ-006 in_valid  input  1  a_in/b_in carry a valid operand pair.
REQ-007 in_ready  output  1  block accepts a pair this cycle.
REQ-008 a_in  input  4  unsigned operand A.
REQ-009 b_in  input  4  unsigned operand B.
REQ-010 sum_out  output  SUM_W  sum of |a-b| over the last completed block.
REQ-011 done  output  1  one-cycle pulse: sum_out just updated.
REQ-012 busy  output  1  high in RUN and DONE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=0 and busy=0; start=1 -> RUN, with accumulator cleared to 0 and pair counter cleared to 0.
REQ-015 RUN: in_ready=1 and busy=1; a pair is accepted iff in_valid && in_ready at the clock edge.
REQ-016 On each accept, accumulator SHALL add |a_in - b_in|, computed as unsigned 4-bit and zero-extended to SUM_W, and the counter SHALL increment.
REQ-017 The accept with counter == N-1 SHALL move the FSM to DONE and load sum_out with the final sum (accumulator + current |a-b|) at the same edge.
REQ-018 DONE lasts exactly one cycle with done=1, in_ready=0 and busy=1, then the FSM SHALL go to IDLE.
REQ-019 Latency: done is high in the cycle immediately after the Nth accept.
REQ-020 Cycles in RUN with in_valid=0 SHALL leave the accumulator and counter unchanged; there is no timeout.
REQ-021 start while in RUN or DONE SHALL be ignored; it is not queued.
REQ-022 start=1 in the same cycle as DONE SHALL be ignored; a new block needs start in IDLE.
REQ-023 sum_out SHALL hold its value until the next block completes, and SHALL NOT be cleared by start.
REQ-024 The accumulator SHALL NOT overflow, per REQ-002; no saturation logic is required.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, accumulator=0, counter=0, sum_out=0, done=0, in_ready=0 and busy=0.
REQ-026 Reset mid-block SHALL discard the partial sum; after release, the block waits for start.

Structure
REQ-027 The state encoding (IDLE/RUN/DONE) and the default N and SUM_W constants SHALL reside in the shared package sad_pkg.
REQ-028 |a-b| SHALL be produced by one instance of the existing abs_dif sub-module (ports aIn, bIn, out; 4-bit); no second subtractor is allowed.
REQ-029 The counter width SHALL be clog2(N), and the counter SHALL wrap only via the clear on start.

Verification (N=8, SUM_W=8)
REQ-030 Uniform: start, then 8 back-to-back pairs (3,12) -> done one cycle after the 8th accept, sum_out=72.
REQ-031 Mixed: pairs (3,12),(10,4),(5,5),(12,0) sent twice -> sum_out=54; the (5,5) pairs contribute 0.
REQ-032 Max/gaps: 8 pairs of (15,0), with in_valid low for 2 cycles between each pair -> sum_out=120, and done occurs exactly once.
REQ-033 Ignored start: start pulsed after the 3rd accept, then a block of all (0,9) -> sum_out=72, and the counter is not reset by that pulse.
REQ-034 Reset mid-op: rst_n low after 3 pairs of (15,0) -> all outputs 0 at once; a new start plus 8 pairs (10,4) -> sum_out=48.
REQ-035 Hold: after a completed block with sum_out=72, IDLE for 10 cycles, then start -> sum_out stays 72 until the next done.
